// File: rtl/adder_pkg.sv
// Shared constants, helpers and FSM state type for the adder sum serializer
// and the companion beat counter.
package adder_pkg;

    localparam int ADDER_WIDTH_DFLT = 152;
    localparam int OUT_WIDTH_DFLT   = 32;

    // Number of OUT_WIDTH beats needed to carry a sumWidth-bit value
    function automatic int calcBeats(input int sumWidth, input int beatWidth);
        return (sumWidth + beatWidth - 1) / beatWidth;
    endfunction

    // Counter width that can hold 0..n-1, never narrower than one bit
    function automatic int cntWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int BEATS_DFLT = calcBeats(ADDER_WIDTH_DFLT + 1, OUT_WIDTH_DFLT);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_t;

endpackage

// File: rtl/ser_beat_counter.sv
// Modulo-COUNT beat counter with synchronous clear and a terminal-count flag.
// Shared between the sum serializer and the operand deserializer.
module ser_beat_counter
    import adder_pkg::*;
#(
    parameter int COUNT = BEATS_DFLT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_inc,
    output logic o_tc
);

    localparam int            CW   = cntWidth(COUNT);
    localparam logic [CW-1:0] LAST = CW'(COUNT - 1);

    logic [CW-1:0] r_count;

    // Clear wins over increment so a fresh load on the final beat restarts at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc) begin
            if (r_count == LAST) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign o_tc = (r_count == LAST);

endmodule

// File: rtl/adder_sum_serializer.sv
// Splits a wide adder sum into LSB-first OUT_WIDTH beats with valid/ready handshakes.
// Optional macro SUM_SER_PARITY_EN adds an out_parity output (XOR of out_data).
module adder_sum_serializer
    import adder_pkg::*;
#(
    parameter int ADDER_WIDTH = ADDER_WIDTH_DFLT,
    parameter int OUT_WIDTH   = OUT_WIDTH_DFLT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDER_WIDTH:0] sum_in,
    input  logic                 sum_valid,
    output logic                 sum_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
`ifdef SUM_SER_PARITY_EN
    output logic                 out_parity,
`endif
    output logic                 out_last
);

    localparam int BEATS   = calcBeats(ADDER_WIDTH + 1, OUT_WIDTH);
    localparam int SHIFT_W = BEATS * OUT_WIDTH;

    ser_state_t         r_state;
    ser_state_t         w_nextState;
    logic [SHIFT_W-1:0] r_shift;
    logic [SHIFT_W-1:0] w_load;
    logic               w_accept;
    logic               w_xfer;
    logic               w_tc;

    ser_beat_counter #(
        .COUNT (BEATS)
    ) u_beatCounter (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_accept),
        .i_inc   (w_xfer),
        .o_tc    (w_tc)
    );

    // Handshake flags and next state; sum_ready depends on out_ready only
    always_comb begin
        w_nextState = r_state;
        sum_ready   = 1'b0;
        out_valid   = 1'b0;
        out_last    = 1'b0;
        case (r_state)
            IDLE: begin
                sum_ready = 1'b1;
                if (sum_valid) begin
                    w_nextState = SEND;
                end
            end
            SEND: begin
                out_valid = 1'b1;
                out_last  = w_tc;
                sum_ready = w_tc && out_ready;
                if (w_tc && out_ready) begin
                    w_nextState = sum_valid ? SEND : IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    assign w_accept = sum_valid && sum_ready;
    assign w_xfer   = out_valid && out_ready;

    always_comb begin
        w_load                = '0;
        w_load[ADDER_WIDTH:0] = sum_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // A new sum overrides the shift on the last-beat handover, keeping beats gapless
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift <= '0;
        end else if (w_accept) begin
            r_shift <= w_load;
        end else if (w_xfer) begin
            r_shift <= r_shift >> OUT_WIDTH;
        end
    end

    assign out_data = r_shift[OUT_WIDTH-1:0];

`ifdef SUM_SER_PARITY_EN
    assign out_parity = ^out_data;
`endif

endmodule

// File: tb/tb_adder_sum_serializer.sv
// Directed, table-driven bench for adder_sum_serializer at default widths,
// with hand-written sequences for back-to-back, stall and mid-sum reset.
module tb_adder_sum_serializer;

    localparam int AW = 152;
    localparam int OW = 32;
    localparam int NV = 6;

    typedef struct {
        logic [AW:0]          sumVal;
        logic [4:0][OW-1:0]   beats;
    } vecT;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW:0]   sum_in;
    logic          sum_valid;
    logic          sum_ready;
    logic [OW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
`ifdef SUM_SER_PARITY_EN
    logic          out_parity;
`endif

    int  total = 0;
    int  bad   = 0;
    vecT vecs[NV];

    adder_sum_serializer #(
        .ADDER_WIDTH (AW),
        .OUT_WIDTH   (OW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sum_in     (sum_in),
        .sum_valid  (sum_valid),
        .sum_ready  (sum_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
`ifdef SUM_SER_PARITY_EN
        .out_parity (out_parity),
`endif
        .out_last   (out_last)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [OW-1:0] actual, input logic [OW-1:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
        end
    endtask

    task automatic checkFlag(input string name, input logic actual, input logic expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %b, want %b", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [AW:0] s, input logic v, input logic r);
        sum_in    = s;
        sum_valid = v;
        out_ready = r;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkBeat(input string tag, input logic [OW-1:0] d, input logic last, input logic rdy);
        checkFlag({tag, " valid"}, out_valid, 1'b1);
        checkOutput({tag, " data"}, out_data, d);
        checkFlag({tag, " last"}, out_last, last);
        checkFlag({tag, " sum_ready"}, sum_ready, rdy);
`ifdef SUM_SER_PARITY_EN
        checkFlag({tag, " parity"}, out_parity, ^d);
`endif
    endtask

    task automatic setVec(input int idx, input logic [AW:0] s,
                          input logic [OW-1:0] b0, input logic [OW-1:0] b1, input logic [OW-1:0] b2,
                          input logic [OW-1:0] b3, input logic [OW-1:0] b4);
        vecs[idx].sumVal   = s;
        vecs[idx].beats[0] = b0;
        vecs[idx].beats[1] = b1;
        vecs[idx].beats[2] = b2;
        vecs[idx].beats[3] = b3;
        vecs[idx].beats[4] = b4;
    endtask

    // Entered one tick after a rising edge with the DUT idle
    task automatic runVector(input vecT v, input string tag);
        checkFlag({tag, " idle sum_ready"}, sum_ready, 1'b1);
        applyStimulus(v.sumVal, 1'b1, 1'b1);
        nextCycle();
        sum_valid = 1'b0;
        for (int b = 0; b < 5; b++) begin
            checkBeat($sformatf("%s b%0d", tag, b), v.beats[b], b == 4, b == 4);
            nextCycle();
        end
        checkFlag({tag, " back to idle valid"}, out_valid, 1'b0);
        checkFlag({tag, " back to idle last"}, out_last, 1'b0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [AW:0] allOnes;
        logic [AW:0] valA;
        logic [AW:0] valB;
        logic [AW:0] valS;
        logic [AW:0] valR;
        logic [OW-1:0] expD;

        allOnes = {(AW + 1){1'b1}};
        setVec(0, 153'h1, 32'h00000001, 32'h0, 32'h0, 32'h0, 32'h0);
        setVec(1, allOnes, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h01FFFFFF);
        setVec(2, 153'h123456789, 32'h23456789, 32'h00000001, 32'h0, 32'h0, 32'h0);
        setVec(3, 153'hABCDEF_DEADBEEF_CAFEBABE_01234567_89ABCDEF,
               32'h89ABCDEF, 32'h01234567, 32'hCAFEBABE, 32'hDEADBEEF, 32'h00ABCDEF);
        setVec(4, 153'h7, 32'h00000007, 32'h0, 32'h0, 32'h0, 32'h0);
        setVec(5, 153'h3, 32'h00000003, 32'h0, 32'h0, 32'h0, 32'h0);

        // Reset state
        rst = 1'b1;
        applyStimulus('0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checkFlag("reset out_valid", out_valid, 1'b0);
        checkFlag("reset out_last", out_last, 1'b0);
        checkOutput("reset out_data", out_data, 32'h0);
`ifdef SUM_SER_PARITY_EN
        checkFlag("reset out_parity", out_parity, 1'b0);
`endif
        rst = 1'b0;
        #1;
        checkFlag("post-reset sum_ready", sum_ready, 1'b1);
        nextCycle();

        for (int i = 0; i < NV; i++) begin
            runVector(vecs[i], $sformatf("vec%0d", i));
        end

        // Back-to-back sums: no bubble, sum_ready only on the last beat of A
        valA = 153'hA;
        valB = 153'hB;
        applyStimulus(valA, 1'b1, 1'b1);
        nextCycle();
        sum_in = valB;
        for (int b = 0; b < 10; b++) begin
            expD = 32'h0;
            if (b == 0) expD = 32'hA;
            if (b == 5) expD = 32'hB;
            checkBeat($sformatf("b2b b%0d", b), expD, (b % 5) == 4, (b % 5) == 4);
            if (b == 5) sum_valid = 1'b0;
            nextCycle();
        end
        checkFlag("b2b idle valid", out_valid, 1'b0);

        // Downstream stall holds the beat; sum_ready stays low on a stalled last beat
        valS = 153'h123456789;
        applyStimulus(valS, 1'b1, 1'b1);
        nextCycle();
        sum_valid = 1'b0;
        checkBeat("stall b0", 32'h23456789, 1'b0, 1'b0);
        nextCycle();
        checkBeat("stall b1", 32'h00000001, 1'b0, 1'b0);
        out_ready = 1'b0;
        nextCycle();
        checkBeat("stall hold1", 32'h00000001, 1'b0, 1'b0);
        nextCycle();
        checkBeat("stall hold2", 32'h00000001, 1'b0, 1'b0);
        out_ready = 1'b1;
        nextCycle();
        checkBeat("stall b2", 32'h0, 1'b0, 1'b0);
        nextCycle();
        checkBeat("stall b3", 32'h0, 1'b0, 1'b0);
        nextCycle();
        checkBeat("stall b4", 32'h0, 1'b1, 1'b1);
        out_ready = 1'b0;
        #1;
        checkFlag("last stalled sum_ready", sum_ready, 1'b0);
        checkFlag("last stalled out_last", out_last, 1'b1);
        out_ready = 1'b1;
        #1;
        checkFlag("last released sum_ready", sum_ready, 1'b1);
        nextCycle();
        checkFlag("stall idle valid", out_valid, 1'b0);

        // Reset in the middle of a sum drops the remaining beats
        valR = 153'h5_00000004_00000003_00000002_00000001;
        applyStimulus(valR, 1'b1, 1'b1);
        nextCycle();
        sum_valid = 1'b0;
        checkBeat("rstmid b0", 32'h00000001, 1'b0, 1'b0);
        nextCycle();
        checkBeat("rstmid b1", 32'h00000002, 1'b0, 1'b0);
        nextCycle();
        rst = 1'b1;
        #1;
        checkFlag("rstmid out_valid", out_valid, 1'b0);
        checkFlag("rstmid out_last", out_last, 1'b0);
        checkOutput("rstmid out_data", out_data, 32'h0);
        nextCycle();
        checkFlag("rstmid next cycle out_valid", out_valid, 1'b0);
        rst = 1'b0;
        #1;
        checkFlag("rstmid release sum_ready", sum_ready, 1'b1);
        nextCycle();
        checkFlag("rstmid no stale beat", out_valid, 1'b0);
        runVector(vecs[3], "after-reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adder_sum_serializer.md
ADDER_SUM_SERIALIZER -- requirements
Module: adder_sum_serializer

Interface
- REQ-001: Parameter ADDER_WIDTH, default 152; adder operand width, so the sum is ADDER_WIDTH+1 bits.
- REQ-002: Parameter OUT_WIDTH, default 32; output beat width.
- REQ-003: Derived constant BEATS = ceil((ADDER_WIDTH+1)/OUT_WIDTH), which is 5 at defaults.
- REQ-004: clk  in  1  sole clock; all state updates on the rising edge.
- REQ-005: rst  in  1  asynchronous, active-high reset.
- REQ-006: sum_in  in  ADDER_WIDTH+1  registered sum from the upstream adder stage.
- REQ-007: sum_valid  in  1  sum_in holds a new result this cycle.
- REQ-008: sum_ready  out  1  serializer accepts sum_in this cycle.
- REQ-009: out_data  out  OUT_WIDTH  current beat, LSB-first.
- REQ-010: out_valid  out  1  out_data is valid.
- REQ-011: out_ready  in  1  downstream accepts the beat.
- REQ-012: out_last  out  1  final beat of the current sum.

Function
- REQ-013: Two-state FSM, IDLE and SEND.
- REQ-014: Accept on sum_valid && sum_ready.
- REQ-015: On accept, sum_in is captured into a shift register zero-extended to BEATS*OUT_WIDTH bits; beat_cnt is set to 0; next state is SEND.
- REQ-016: IDLE: sum_ready=1, out_valid=0, out_last=0.
- REQ-017: SEND: out_valid=1; out_data = shift_reg[OUT_WIDTH-1:0].
- REQ-018: out_last=1 iff state is SEND and beat_cnt==BEATS-1.
- REQ-019: A beat transfers on out_valid && out_ready; on transfer, shift_reg shifts right by OUT_WIDTH and beat_cnt increments.
- REQ-020: With out_ready=0, out_data, out_valid and out_last hold stable.
- REQ-021: sum_ready = IDLE || (out_last && out_ready), combinational from out_ready only; there is no path from sum_valid to sum_ready.
- REQ-022: Last-beat transfer without a simultaneous accept: next state is IDLE.
- REQ-023: Last-beat transfer with a simultaneous accept: the new sum is loaded, beat_cnt=0, state stays SEND; no bubble between sums.
- REQ-024: sum_valid while sum_ready=0 is not captured; upstream must hold the value.
- REQ-025: The final beat carries the upper ADDER_WIDTH+1-(BEATS-1)*OUT_WIDTH sum bits, with the remaining high bits zero.
- REQ-026: Throughput is one sum per BEATS cycles under continuous out_ready=1.
- REQ-027: Latency from accept to the first out_valid is exactly 1 cycle.

Reset
- REQ-028: rst asserted forces state=IDLE, beat_cnt=0, shift_reg=0, out_valid=0, out_last=0, out_data=0, and sum_ready=1 once rst is released.
- REQ-029: Reset during SEND discards the partial sum; no further beats of it are emitted.

Configuration
- REQ-030: Macro SUM_SER_PARITY_EN defined: the block adds output out_parity (1 bit), the even parity (XOR reduction) of out_data, valid whenever out_valid=1, and 0 in reset.
- REQ-031: Macro SUM_SER_PARITY_EN undefined: the out_parity port and its logic are absent, and the block's behaviour is otherwise identical.

Structure
- REQ-032: Shared package adder_pkg holds ADDER_WIDTH, OUT_WIDTH and BEATS defaults and the FSM state enum {IDLE, SEND}.
- REQ-033: The beat counter is a single sub-module, ser_beat_counter (clear, inc, terminal-count flag), reused by a future operand deserializer.
- REQ-034: All other logic is flat in adder_sum_serializer.

Verification
- REQ-035: sum_in=153'h1, out_ready=1 -> beats 0x00000001,0,0,0,0; out_last only on beat 5; return to IDLE.
- REQ-036: sum_in=all ones (153 bits) -> four beats 0xFFFFFFFF, then 0x01FFFFFF with out_last=1.
- REQ-037: Back-to-back: sum_valid held high with 0xA then 0xB -> 10 consecutive valid beats, no gap; sum_ready high only on the last beat of A.
- REQ-038: out_ready toggled 1,0,0,1 during sum 0x123456789 -> out_data held stable while stalled; beats 0x23456789, 0x00000001, 0,0,0.
- REQ-039: rst pulsed after beat 2 of a sum -> out_valid=0 next cycle; the next sum starts at beat 0 with correct data.
- REQ-040: With SUM_SER_PARITY_EN defined, beat 0x00000007 -> out_parity=1; beat 0x00000003 -> out_parity=0.
